uart_receiver_param: RTL



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_tick_gen.sv | 37 +++
 rtl/uart_receiver_param.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: baud divisors, FSM states and parity helper.
// Divisors are tabulated for 16x oversampling and rescaled for other ratios.
package uart_pkg;

    localparam int DIV_W = 14;

    localparam logic [DIV_W-1:0] DIV_TABLE [0:7] = '{
        14'd10417, 14'd2604, 14'd651, 14'd326, 14'd163, 14'd81, 14'd54, 14'd27
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    // Rescale to the actual oversample ratio, saturating to what the 14-bit counter can hold.
    function automatic logic [DIV_W-1:0] div_lookup(input logic [2:0] sel, input int oversample);
        int scaled;
        scaled = (int'(DIV_TABLE[sel]) * 16) / oversample;
        if (scaled > (1 << DIV_W) - 1) scaled = (1 << DIV_W) - 1;
        if (scaled < 2) scaled = 2;
        return DIV_W'(scaled);
    endfunction

    function automatic logic even_parity(input logic [8:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: down-counter reloading with DIV-1, one-clk tick at zero.
// Held at the reload value while disabled so the first tick lands one full period after enable.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] baud_sel,
    output logic       tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] reload;

    always_comb begin
        reload = div_lookup(baud_sel, OVERSAMPLE) - 1'b1;
        tick   = enable && (cnt_q == '0);
        if (!enable || tick) begin
            cnt_d = reload;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_receiver_param.sv
// Parametrised UART receiver with 3-sample majority voting, optional parity and 1-2 stop bits.
// Flags pulse one clk after the last stop-bit vote; no backpressure, baud_select frozen per frame.
module uart_receiver_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           baud_select,
    input  logic                 RX_EN,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_FERROR,
    output logic                 Rx_PERROR
);

    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_LO      = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID     = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_HI      = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    rx_state_e            state_q, state_d;
    logic                 sync1_q, sync1_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
    logic [2:0]           baud_q, baud_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 par_err_q, par_err_d, stop_err_q, stop_err_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;

    logic          tick, tick_en, vote, vote_now, bit_end, stop_bad;
    logic [TW-1:0] tcnt_inc;
    logic [2:0]    tick_baud;

    // While idle the divider tracks the live select so a new frame starts at the new rate.
    assign tick_en   = (state_q != ST_IDLE);
    assign tick_baud = (state_q == ST_IDLE) ? baud_select : baud_q;

    uart_rx_tick_gen #(.OVERSAMPLE(OVERSAMPLE)) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .enable   (tick_en),
        .baud_sel (tick_baud),
        .tick     (tick)
    );

    always_comb begin
        sync1_d    = RxD;
        rxs_d      = sync1_q;
        rxs_prev_d = rxs_q;
        state_d    = state_q;
        baud_d     = baud_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;

        tcnt_inc = (tcnt_q == T_LAST) ? '0 : tcnt_q + 1'b1;
        bit_end  = tick && (tcnt_q == T_LAST);
        vote_now = tick && (tcnt_inc == T_HI);
        vote     = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
        stop_bad = stop_err_q | ~vote;

        if (tick && state_q != ST_IDLE && state_q != ST_WAIT_IDLE) begin
            tcnt_d = tcnt_inc;
            if (tcnt_inc == T_LO)  s0_d = rxs_q;
            if (tcnt_inc == T_MID) s1_d = rxs_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (RX_EN && rxs_prev_q && !rxs_q) begin
                    state_d    = ST_START;
                    baud_d     = baud_select;
                    tcnt_d     = '0;
                    bcnt_d     = '0;
                    par_err_d  = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (vote_now && vote) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                    bcnt_d  = '0;
                end
            end
            ST_DATA: begin
                if (vote_now) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bcnt_q == LAST_DATA) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (vote_now) par_err_d = vote ^ even_parity(9'(shift_q)) ^ PAR_ODD;
                if (bit_end) begin
                    state_d = ST_STOP;
                    bcnt_d  = '0;
                end
            end
            ST_STOP: begin
                if (vote_now) begin
                    if (bcnt_q == LAST_STOP) begin
                        data_d  = shift_q;
                        ferr_d  = stop_bad;
                        perr_d  = par_err_q;
                        valid_d = ~stop_bad & ~par_err_q;
                        state_d = stop_bad ? ST_WAIT_IDLE : ST_IDLE;
                        tcnt_d  = '0;
                    end else begin
                        stop_err_d = stop_bad;
                    end
                end else if (bit_end) begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                // A break must release for a whole bit before another start edge is trusted.
                if (!rxs_q) begin
                    tcnt_d = '0;
                end else if (tick) begin
                    if (tcnt_q == T_LAST) begin
                        state_d = ST_IDLE;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!RX_EN) begin
            state_d = ST_IDLE;
            data_d  = data_q;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            baud_q     <= '0;
            tcnt_q     <= '0;
            bcnt_q     <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
            baud_q     <= baud_d;
            tcnt_q     <= tcnt_d;
            bcnt_q     <= bcnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_FERROR = ferr_q;
    assign Rx_PERROR = perr_q;

endmodule
